// File: rtl/overlay_compositor.sv
// ----------------------------------------------------------------------------
// overlay_compositor
//
// Draws up to N_CIRCLES filled circles over the palette background on the VGA
// path, between the VGA controller and the DAC pins. Slot 0 has the highest
// priority.
//
// Circle attributes are written into a shadow bank at any time. The shadow
// bank is copied into the active bank at frame start, so a frame is always
// drawn from one consistent set of attributes.
//
// A frame counter drives the per-slot blink mode. The blink phase toggles every
// BLINK_FRAMES frames.
//
// The 3-stage pixel pipeline advances only on pix_en.
//   S1  per-slot signed offsets from the circle centre; bank attributes latched
//   S2  per-slot containment test (squared distance vs squared radius)
//   S3  priority select against background, blanking, output registers
//
// Ports
//   CLK                  system clock
//   Reset                synchronous, active-high
//   pix_en               pixel strobe; every pipeline register holds when 0
//   frame_start          first pixel of a frame (only meaningful with pix_en)
//   blank                1 = active video, 0 = blanking
//   DrawX, DrawY         current pixel coordinate
//   bg_red/green/blue    background colour aligned with DrawX/DrawY
//   cfg_we ... cfg_blink shadow-bank write port (one slot per cycle)
//   cfg_err              1-cycle pulse after a write to a nonexistent slot
//   Red, Green, Blue     registered pixel colour
//   pix_valid            1 when Red/Green/Blue carry an active-video pixel
//
// Config port protocol:
//   The write port has no ready signal. Every cycle with cfg_we=1 is consumed
//   in that cycle, whatever the value of pix_en.
//   - An in-range cfg_idx overwrites every field of that shadow slot.
//   - An out-of-range cfg_idx changes nothing and raises cfg_err on the next
//     cycle.
// ----------------------------------------------------------------------------
module overlay_compositor #(
  parameter int N_CIRCLES    = 8,
  parameter int COORD_W      = 10,
  parameter int RAD_W        = 6,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 30,
  // The index is wide enough to encode N_CIRCLES itself. A power-of-two slot
  // count can therefore still receive (and reject) an out-of-range index.
  localparam int IDX_W = $clog2(N_CIRCLES + 1)
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   pix_en,
  input  logic                   frame_start,
  input  logic                   blank,
  input  logic [COORD_W-1:0]     DrawX,
  input  logic [COORD_W-1:0]     DrawY,
  input  logic [COLOR_W-1:0]     bg_red,
  input  logic [COLOR_W-1:0]     bg_green,
  input  logic [COLOR_W-1:0]     bg_blue,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [COORD_W-1:0]     cfg_x,
  input  logic [COORD_W-1:0]     cfg_y,
  input  logic [RAD_W-1:0]       cfg_r,
  input  logic [3*COLOR_W-1:0]   cfg_rgb,
  input  logic                   cfg_en,
  input  logic                   cfg_blink,
  output logic                   cfg_err,
  output logic [COLOR_W-1:0]     Red,
  output logic [COLOR_W-1:0]     Green,
  output logic [COLOR_W-1:0]     Blue,
  output logic                   pix_valid
);

  localparam int SEL_W = (N_CIRCLES > 1) ? $clog2(N_CIRCLES) : 1;
  localparam int D_W   = COORD_W + 1;       // signed offset width
  // The sum of two squared offsets needs this width to avoid overflow.
  localparam int SUM_W = 2 * D_W + 1;
  localparam int RGB_W = 3 * COLOR_W;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // --------------------------------------------------------------------------
  // Attribute banks
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] shX     [N_CIRCLES];
  logic [COORD_W-1:0] shY     [N_CIRCLES];
  logic [RAD_W-1:0]   shR     [N_CIRCLES];
  logic [RGB_W-1:0]   shRgb   [N_CIRCLES];
  logic               shEn    [N_CIRCLES];
  logic               shBlink [N_CIRCLES];

  logic [COORD_W-1:0] actX     [N_CIRCLES];
  logic [COORD_W-1:0] actY     [N_CIRCLES];
  logic [RAD_W-1:0]   actR     [N_CIRCLES];
  logic [RGB_W-1:0]   actRgb   [N_CIRCLES];
  logic               actEn    [N_CIRCLES];
  logic               actBlink [N_CIRCLES];

  logic             swap;
  logic             cfgOk;
  logic [SEL_W-1:0] cfgSel;

  assign swap   = frame_start & pix_en;
  assign cfgOk  = cfg_we && (cfg_idx < IDX_W'(N_CIRCLES));
  assign cfgSel = cfg_idx[SEL_W-1:0];

  // The copy reads the old shadow contents, because all bank updates are
  // non-blocking. A write in the same cycle as the swap therefore lands in the
  // shadow after the copy, and first shows in the following frame.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < N_CIRCLES; i++) begin
        shX[i]      <= '0;
        shY[i]      <= '0;
        shR[i]      <= '0;
        shRgb[i]    <= '0;
        shEn[i]     <= 1'b0;
        shBlink[i]  <= 1'b0;
        actX[i]     <= '0;
        actY[i]     <= '0;
        actR[i]     <= '0;
        actRgb[i]   <= '0;
        actEn[i]    <= 1'b0;
        actBlink[i] <= 1'b0;
      end
    end else begin
      cfg_err <= cfg_we & ~cfgOk;
      for (int i = 0; i < N_CIRCLES; i++) begin
        if (swap) begin
          actX[i]     <= shX[i];
          actY[i]     <= shY[i];
          actR[i]     <= shR[i];
          actRgb[i]   <= shRgb[i];
          actEn[i]    <= shEn[i];
          actBlink[i] <= shBlink[i];
        end
        if (cfgOk && (cfgSel == SEL_W'(i))) begin
          shX[i]     <= cfg_x;
          shY[i]     <= cfg_y;
          shR[i]     <= cfg_r;
          shRgb[i]   <= cfg_rgb;
          shEn[i]    <= cfg_en;
          shBlink[i] <= cfg_blink;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame counter and blink phase
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] frameCnt;
  logic             blinkPhase;
  logic             cntWrap;
  logic             effPhase;

  assign cntWrap = (frameCnt == CNT_W'(BLINK_FRAMES - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      frameCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (swap) begin
      if (cntWrap) begin
        frameCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        frameCnt <= frameCnt + CNT_W'(1);
      end
    end
  end

  // The frame_start pixel is the first pixel of the new frame. It must see the
  // bank and blink phase that take effect at this edge, so both are forwarded
  // here instead of being read from the registers.
  assign effPhase = blinkPhase ^ (swap & cntWrap);

  // --------------------------------------------------------------------------
  // S1: per-slot offsets; latch the bank attributes this pixel will use
  // --------------------------------------------------------------------------
  logic signed [D_W-1:0] nxtDx   [N_CIRCLES];
  logic signed [D_W-1:0] nxtDy   [N_CIRCLES];
  logic [RAD_W-1:0]      nxtR    [N_CIRCLES];
  logic [RGB_W-1:0]      nxtRgb  [N_CIRCLES];
  logic                  nxtLive [N_CIRCLES];

  always_comb begin
    for (int i = 0; i < N_CIRCLES; i++) begin
      nxtDx[i]   = $signed({1'b0, DrawX}) - $signed({1'b0, (swap ? shX[i] : actX[i])});
      nxtDy[i]   = $signed({1'b0, DrawY}) - $signed({1'b0, (swap ? shY[i] : actY[i])});
      nxtR[i]    = swap ? shR[i] : actR[i];
      nxtRgb[i]  = swap ? shRgb[i] : actRgb[i];
      // "Live" means the slot can draw in this frame: it is enabled, has a
      // nonzero radius, and is not hidden by the blink phase.
      nxtLive[i] = (swap ? shEn[i] : actEn[i])
                 & ((swap ? shR[i] : actR[i]) != '0)
                 & (~(swap ? shBlink[i] : actBlink[i]) | ~effPhase);
    end
  end

  logic signed [D_W-1:0] s1Dx   [N_CIRCLES];
  logic signed [D_W-1:0] s1Dy   [N_CIRCLES];
  logic [RAD_W-1:0]      s1R    [N_CIRCLES];
  logic [RGB_W-1:0]      s1Rgb  [N_CIRCLES];
  logic                  s1Live [N_CIRCLES];
  logic [RGB_W-1:0]      s1Bg;
  logic                  s1Blank;
  logic                  s1Valid;

  // --------------------------------------------------------------------------
  // S2: containment test, boundary inclusive
  // --------------------------------------------------------------------------
  logic signed [SUM_W-1:0] dxE    [N_CIRCLES];
  logic signed [SUM_W-1:0] dyE    [N_CIRCLES];
  logic [SUM_W-1:0]        rE     [N_CIRCLES];
  logic [SUM_W-1:0]        distSq [N_CIRCLES];
  logic [SUM_W-1:0]        rSq    [N_CIRCLES];
  logic [N_CIRCLES-1:0]    hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CIRCLES; i++) begin
      // Sign-extend the offsets to the full sum width before squaring. Far
      // pixels then produce large positive distances and never wrap around.
      dxE[i]    = {{(SUM_W-D_W){s1Dx[i][D_W-1]}}, s1Dx[i]};
      dyE[i]    = {{(SUM_W-D_W){s1Dy[i][D_W-1]}}, s1Dy[i]};
      rE[i]     = {{(SUM_W-RAD_W){1'b0}}, s1R[i]};
      distSq[i] = dxE[i] * dxE[i] + dyE[i] * dyE[i];
      rSq[i]    = rE[i] * rE[i];
      hit[i]    = s1Live[i] & (distSq[i] <= rSq[i]);
    end
  end

  logic [N_CIRCLES-1:0] s2Hit;
  logic [RGB_W-1:0]     s2Rgb [N_CIRCLES];
  logic [RGB_W-1:0]     s2Bg;
  logic                 s2Blank;
  logic                 s2Valid;

  // --------------------------------------------------------------------------
  // S3: lowest-index hit wins; otherwise background
  // --------------------------------------------------------------------------
  logic [RGB_W-1:0] winRgb;

  always_comb begin
    winRgb = s2Bg;
    for (int i = N_CIRCLES - 1; i >= 0; i--) begin
      if (s2Hit[i]) begin
        winRgb = s2Rgb[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers. Reset clears the valid bits and aborts pixels in
  // flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1Bg      <= '0;
      s1Blank   <= 1'b0;
      s1Valid   <= 1'b0;
      s2Hit     <= '0;
      s2Bg      <= '0;
      s2Blank   <= 1'b0;
      s2Valid   <= 1'b0;
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      pix_valid <= 1'b0;
      for (int i = 0; i < N_CIRCLES; i++) begin
        s1Dx[i]   <= '0;
        s1Dy[i]   <= '0;
        s1R[i]    <= '0;
        s1Rgb[i]  <= '0;
        s1Live[i] <= 1'b0;
        s2Rgb[i]  <= '0;
      end
    end else if (pix_en) begin
      // S1
      s1Bg    <= {bg_red, bg_green, bg_blue};
      s1Blank <= blank;
      s1Valid <= 1'b1;
      for (int i = 0; i < N_CIRCLES; i++) begin
        s1Dx[i]   <= nxtDx[i];
        s1Dy[i]   <= nxtDy[i];
        s1R[i]    <= nxtR[i];
        s1Rgb[i]  <= nxtRgb[i];
        s1Live[i] <= nxtLive[i];
      end
      // S2
      s2Hit   <= hit;
      s2Bg    <= s1Bg;
      s2Blank <= s1Blank;
      s2Valid <= s1Valid;
      for (int i = 0; i < N_CIRCLES; i++) begin
        s2Rgb[i] <= s1Rgb[i];
      end
      // S3: blanking and pipeline-fill pixels drive black
      if (s2Valid && s2Blank) begin
        {Red, Green, Blue} <= winRgb;
        pix_valid          <= 1'b1;
      end else begin
        {Red, Green, Blue} <= '0;
        pix_valid          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_overlay_compositor.sv
// ----------------------------------------------------------------------------
// tb_overlay_compositor
//
// Reference model: circle attributes are kept as plain integers. Each pixel is
// evaluated from the geometric rule (dx^2 + dy^2 <= r^2) over the active slot
// list, in priority order.
//
// A pixel's expected value enters exp_q on its pix_en beat. The queue is seeded
// with two idle entries after reset. Each beat pops the value that should sit
// on the outputs after that beat.
// ----------------------------------------------------------------------------
module tb_overlay_compositor;

  localparam int N  = 8;
  localparam int BF = 2;
  localparam logic [11:0] BG = 12'h123;

  typedef struct {
    int          x;
    int          y;
    int          r;
    logic [11:0] rgb;
    bit          en;
    bit          blink;
  } slot_t;

  // Clock and reset
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        pix_en = 1'b0, frame_start = 1'b0, blank = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [3:0]  bg_red = '0, bg_green = '0, bg_blue = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [9:0]  cfg_x = '0, cfg_y = '0;
  logic [5:0]  cfg_r = '0;
  logic [11:0] cfg_rgb = '0;
  logic        cfg_en = 1'b0, cfg_blink = 1'b0;
  logic        cfg_err;
  logic [3:0]  Red, Green, Blue;
  logic        pix_valid;

  overlay_compositor #(
    .N_CIRCLES(N), .COORD_W(10), .RAD_W(6), .COLOR_W(4), .BLINK_FRAMES(BF)
  ) dut (
    .CLK(CLK), .Reset(Reset), .pix_en(pix_en), .frame_start(frame_start),
    .blank(blank), .DrawX(DrawX), .DrawY(DrawY),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_r(cfg_r), .cfg_rgb(cfg_rgb), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .cfg_err(cfg_err), .Red(Red), .Green(Green), .Blue(Blue),
    .pix_valid(pix_valid)
  );

  // Model state and scoreboard
  slot_t       mShadow [N];
  slot_t       mActive [N];
  int          mFrameCnt;
  bit          mPhase;
  logic [12:0] exp_q[$];
  logic [12:0] expNow;
  bit          expErr;
  logic [12:0] obs;
  logic        obsErr;
  slot_t       noCfg;
  int          errors = 0;
  int          checks = 0;

  function automatic slot_t mk(int x, int y, int r, logic [11:0] rgb, bit en, bit bl);
    slot_t s;
    s.x = x; s.y = y; s.r = r; s.rgb = rgb; s.en = en; s.blink = bl;
    return s;
  endfunction

  function automatic logic [12:0] model_pixel(int x, int y, logic [11:0] bg, bit bl);
    logic [11:0] c;
    int ddx, ddy;
    c = bg;
    if (!bl) return 13'd0;
    for (int i = 0; i < N; i++) begin
      ddx = x - mActive[i].x;
      ddy = y - mActive[i].y;
      if (mActive[i].en && mActive[i].r > 0 && (!mActive[i].blink || !mPhase) &&
          (ddx * ddx + ddy * ddy <= mActive[i].r * mActive[i].r)) begin
        c = mActive[i].rgb;
        break;
      end
    end
    return {1'b1, c};
  endfunction

  // Driver: one clock cycle of stimulus; updates the model and samples outputs
  task automatic drive_cycle(input bit pe, input bit fs, input int x, input int y,
                             input logic [11:0] bg, input bit bl,
                             input bit we, input int idx, input slot_t c);
    pix_en = pe; frame_start = fs; blank = bl;
    DrawX = 10'(x); DrawY = 10'(y);
    {bg_red, bg_green, bg_blue} = bg;
    cfg_we = we; cfg_idx = 4'(idx);
    cfg_x = 10'(c.x); cfg_y = 10'(c.y); cfg_r = 6'(c.r);
    cfg_rgb = c.rgb; cfg_en = c.en; cfg_blink = c.blink;
    @(posedge CLK);
    if (pe) begin
      if (fs) begin
        for (int i = 0; i < N; i++) mActive[i] = mShadow[i];
        if (mFrameCnt == BF - 1) begin
          mFrameCnt = 0;
          mPhase = ~mPhase;
        end else begin
          mFrameCnt++;
        end
      end
      exp_q.push_back(model_pixel(x, y, bg, bl));
      expNow = exp_q.pop_front();
    end
    expErr = we && (idx >= N);
    if (we && idx < N) mShadow[idx] = c;
    #1;
    obs    = {pix_valid, Red, Green, Blue};
    obsErr = cfg_err;
    pix_en = 1'b0; frame_start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic [11:0] bg, input bit bl);
    drive_cycle(1, 0, x, y, bg, bl, 0, 0, noCfg);
  endtask

  task automatic frame(input int x, input int y, input logic [11:0] bg);
    drive_cycle(1, 1, x, y, bg, 1, 0, 0, noCfg);
  endtask

  task automatic write_slot(input int idx, input slot_t c);
    drive_cycle(0, 0, 0, 0, 12'h000, 1, 1, idx, c);
  endtask

  task automatic do_reset();
    Reset = 1'b1; pix_en = 1'b0; frame_start = 1'b0; cfg_we = 1'b0;
    @(posedge CLK);
    #1;
    obs = {pix_valid, Red, Green, Blue};
    obsErr = cfg_err;
    Reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      mShadow[i] = mk(0, 0, 0, 12'h000, 0, 0);
      mActive[i] = mk(0, 0, 0, 12'h000, 0, 0);
    end
    mFrameCnt = 0;
    mPhase = 1'b0;
    exp_q.delete();
    exp_q.push_back(13'd0);
    exp_q.push_back(13'd0);
    checks++;
    if (obs !== 13'd0 || obsErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rgbv=%h err=%b want 0000 0", obs, obsErr);
    end
  endtask

  task automatic test_reset();
    logic [11:0] bgs [3];
    bgs = '{12'h357, 12'h468, 12'h9AB};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pixel(k * 10, 5, bgs[k], 1);
      checks++;
      if (obs !== expNow) begin
        errors++;
        $display("FAIL bg_stream beat %0d: got %h want %h", k, obs, expNow);
      end
    end
    checks++;
    if (obs !== 13'h1357) begin
      errors++;
      $display("FAIL bg_latency: got %h want 1357", obs);
    end
  endtask

  task automatic test_circle();
    int px [7];
    int py [7];
    px = '{108, 109, 92, 100, 105, 106, 0};
    py = '{50, 50, 50, 42, 56, 56, 0};
    do_reset();
    write_slot(0, mk(100, 50, 8, 12'h0F0, 1, 0));
    frame(0, 0, BG);
    for (int k = 0; k < 7; k++) begin
      pixel(px[k], py[k], BG, 1);
      checks++;
      if (obs !== expNow) begin
        errors++;
        $display("FAIL circle_edge beat %0d: got %h want %h", k, obs, expNow);
      end
      if (k == 2 && obs !== 13'h10F0) begin
        errors++;
        $display("FAIL circle_inclusive: got %h want 10f0", obs);
      end
      if (k == 3 && obs !== {1'b1, BG}) begin
        errors++;
        $display("FAIL circle_outside: got %h want %h", obs, {1'b1, BG});
      end
      if (k == 2 || k == 3) checks++;
    end
    write_slot(0, mk(100, 50, 0, 12'h0F0, 1, 0));
    frame(100, 50, BG);
    for (int k = 0; k < 3; k++) begin
      pixel(100, 50, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== {1'b1, BG})) begin
        errors++;
        $display("FAIL radius_zero beat %0d: got %h want %h", k, obs, expNow);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    write_slot(0, mk(320, 240, 10, 12'hF00, 1, 0));
    write_slot(1, mk(320, 240, 10, 12'h00F, 1, 0));
    frame(320, 240, BG);
    for (int k = 0; k < 2; k++) begin
      pixel(320, 240, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== 13'h1F00)) begin
        errors++;
        $display("FAIL priority_red beat %0d: got %h want %h", k, obs, expNow);
      end
    end
    write_slot(0, mk(320, 240, 10, 12'hF00, 0, 0));
    frame(320, 240, BG);
    for (int k = 0; k < 2; k++) begin
      pixel(320, 240, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== 13'h100F)) begin
        errors++;
        $display("FAIL priority_blue beat %0d: got %h want %h", k, obs, expNow);
      end
    end
  endtask

  task automatic test_cfg_timing();
    do_reset();
    // write coinciding with frame_start lands after the copy
    drive_cycle(1, 1, 500, 300, BG, 1, 1, 2, mk(500, 300, 5, 12'hFFF, 1, 0));
    for (int k = 0; k < 2; k++) begin
      pixel(500, 300, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== {1'b1, BG})) begin
        errors++;
        $display("FAIL write_at_swap beat %0d: got %h want %h", k, obs, expNow);
      end
    end
    frame(500, 300, BG);
    for (int k = 0; k < 2; k++) begin
      pixel(500, 300, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== 13'h1FFF)) begin
        errors++;
        $display("FAIL write_next_frame beat %0d: got %h want %h", k, obs, expNow);
      end
    end
    // An out-of-range index aliases slot 1 on its low bits; a leaked write
    // would outrank slot 2.
    write_slot(9, mk(500, 300, 20, 12'h00F, 1, 0));
    checks++;
    if (obsErr !== 1'b1 || expErr !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_idx9: got %b want 1", obsErr);
    end
    drive_cycle(0, 0, 0, 0, BG, 1, 0, 0, noCfg);
    checks++;
    if (obsErr !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse: got %b want 0", obsErr);
    end
    write_slot(8, mk(500, 300, 20, 12'h00F, 1, 0));
    checks++;
    if (obsErr !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_idx8: got %b want 1", obsErr);
    end
    write_slot(7, mk(0, 0, 0, 12'h000, 0, 0));
    checks++;
    if (obsErr !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_idx7: got %b want 0", obsErr);
    end
    frame(500, 300, BG);
    for (int k = 0; k < 2; k++) begin
      pixel(500, 300, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== 13'h1FFF)) begin
        errors++;
        $display("FAIL bad_idx_no_write beat %0d: got %h want %h", k, obs, expNow);
      end
    end
  endtask

  task automatic test_blink_hold();
    logic [12:0] held;
    logic [12:0] want;
    do_reset();
    write_slot(0, mk(200, 200, 6, 12'hABC, 1, 1));
    for (int j = 1; j <= 6; j++) begin
      frame(200, 200, BG);
      pixel(200, 200, BG, 1);
      pixel(200, 200, BG, 1);
      // phase after j frame starts: toggles every BF frames
      want = (((j / BF) % 2) == 0) ? 13'h1ABC : {1'b1, BG};
      checks++;
      if (obs !== expNow || obs !== want) begin
        errors++;
        $display("FAIL blink frame %0d: got %h want %h", j, obs, want);
      end
    end
    pixel(1, 1, BG, 1);
    held = obs;
    for (int k = 0; k < 3; k++) begin
      // frame_start without pix_en must be ignored as well
      drive_cycle(0, 1, 200 + k * 7, 200, 12'hFFF, 1, 0, 0, noCfg);
      checks++;
      if (obs !== held) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h want %h", k, obs, held);
      end
    end
    for (int k = 0; k < 3; k++) begin
      pixel(200, 200, BG, 1);
      checks++;
      if (obs !== expNow) begin
        errors++;
        $display("FAIL hold_resume beat %0d: got %h want %h", k, obs, expNow);
      end
    end
  endtask

  task automatic test_blank_reset();
    do_reset();
    write_slot(0, mk(300, 300, 10, 12'hFFF, 1, 0));
    frame(0, 0, BG);
    pixel(300, 300, BG, 0);
    pixel(300, 300, BG, 1);
    checks++;
    if (obs !== expNow) begin
      errors++;
      $display("FAIL blank_pre: got %h want %h", obs, expNow);
    end
    pixel(0, 0, BG, 1);
    checks++;
    if (obs !== 13'd0 || obs !== expNow) begin
      errors++;
      $display("FAIL blank_inside: got %h want 0000", obs);
    end
    pixel(0, 0, BG, 1);
    checks++;
    if (obs !== 13'h1FFF) begin
      errors++;
      $display("FAIL blank_active: got %h want 1fff", obs);
    end
    pixel(300, 300, BG, 1);
    pixel(300, 300, BG, 1);
    do_reset();
    frame(300, 300, BG);
    for (int k = 0; k < 3; k++) begin
      pixel(300, 300, BG, 1);
      checks++;
      if (obs !== expNow || (k == 1 && obs !== {1'b1, BG})) begin
        errors++;
        $display("FAIL post_reset beat %0d: got %h want %h", k, obs, expNow);
      end
    end
  endtask

  task automatic test_no_wrap();
    int px [8];
    int py [8];
    px = '{1023, 1023, 0, 63, 45, 44, 64, 0};
    py = '{1023, 0, 1023, 0, 45, 44, 0, 0};
    do_reset();
    write_slot(0, mk(0, 0, 63, 12'h5A5, 1, 0));
    write_slot(3, mk(1023, 1023, 2, 12'h0CC, 1, 0));
    frame(512, 512, BG);
    for (int k = 0; k < 8; k++) begin
      pixel(px[k], py[k], BG, 1);
      checks++;
      if (obs !== expNow) begin
        errors++;
        $display("FAIL far_coord beat %0d: got %h want %h", k, obs, expNow);
      end
    end
    pixel(0, 0, BG, 1);
    pixel(0, 0, BG, 1);
    checks++;
    if (obs !== expNow) begin
      errors++;
      $display("FAIL far_coord tail: got %h want %h", obs, expNow);
    end
  endtask

  task automatic test_random();
    logic [12:0] prev;
    int sx, sy, s, x, y, idx;
    bit pe, fs, we, bl;
    do_reset();
    for (int i = 0; i < N; i++)
      write_slot(i, mk($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 63),
                       12'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0)));
    frame(0, 0, BG);
    prev = obs;
    for (int n = 0; n < 1500; n++) begin
      pe  = ($urandom_range(0, 4) != 0);
      fs  = ($urandom_range(0, 24) == 0);
      we  = ($urandom_range(0, 9) == 0);
      bl  = ($urandom_range(0, 9) != 0);
      idx = $urandom_range(0, 9);
      s   = $urandom_range(0, N - 1);
      sx  = mShadow[s].x + $urandom_range(0, 140) - 70;
      sy  = mShadow[s].y + $urandom_range(0, 140) - 70;
      x   = (sx < 0) ? 0 : (sx > 1023) ? 1023 : sx;
      y   = (sy < 0) ? 0 : (sy > 1023) ? 1023 : sy;
      drive_cycle(pe, fs, x, y, 12'($urandom), bl, we,
                  idx, mk($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 63),
                          12'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0)));
      checks++;
      if (pe && obs !== expNow) begin
        errors++;
        $display("FAIL random_pixel n=%0d: got %h want %h", n, obs, expNow);
      end else if (!pe && obs !== prev) begin
        errors++;
        $display("FAIL random_hold n=%0d: got %h want %h", n, obs, prev);
      end
      checks++;
      if (obsErr !== expErr) begin
        errors++;
        $display("FAIL random_cfg_err n=%0d: got %b want %b", n, obsErr, expErr);
      end
      prev = obs;
    end
  endtask

  initial begin
    noCfg = mk(0, 0, 0, 12'h000, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_circle();
    test_priority();
    test_cfg_timing();
    test_blink_hold();
    test_blank_reset();
    test_no_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
